// File: rtl/ram_pkg.sv
// Shared constants and types for the single-port RAM and its burst master.
package ram_pkg;

  localparam int RAM_ADDR_WIDTH = 16;
  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_DEPTH      = 65536;
  localparam int RAM_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // A burst carries len+1 beats, so the all-ones value means 256 beats.
  typedef logic [RAM_LEN_WIDTH-1:0] burst_len_t;

endpackage

// File: rtl/ram_burst_master_if.sv
// Client request/stream signals plus the RAM pin bundle driven by the burst master.
interface ram_burst_master_if
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = RAM_LEN_WIDTH
);

  // req and wdata transfer on a cycle where valid and ready are both high at the
  // clock edge; rdata has no ready, the client takes every beat flagged by rdata_valid.
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;

  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;

  logic                  rdata_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_last;
  logic                  done;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_data_out;

  state_e                dbg_state;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    output req_ready,
    input  wdata_valid, wdata,
    output wdata_ready,
    output rdata_valid, rdata, rdata_last, done,
    output mem_address, mem_data_in, mem_we,
    input  mem_data_out,
    output dbg_state
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    input  req_ready,
    output wdata_valid, wdata,
    input  wdata_ready,
    input  rdata_valid, rdata, rdata_last, done,
    input  mem_address, mem_data_in, mem_we,
    output mem_data_out,
    input  dbg_state
  );

endinterface

// File: rtl/ram_rd_pipe.sv
// Two-stage valid/last shift register that lines issued read addresses up with
// the RAM's registered data_out and captures the returned byte.
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic                  iss_last,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic                  last_pending
);

  logic s1_valid;
  logic s1_last;

  // Stage 1 marks the cycle in which the RAM presents the addressed byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_last     <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      rdata       <= '0;
    end else begin
      s1_valid    <= iss_valid;
      s1_last     <= iss_valid & iss_last;
      rdata_valid <= s1_valid;
      rdata_last  <= s1_last;
      if (s1_valid) rdata <= mem_data_out;
    end
  end

  assign last_pending = s1_last;

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for the 64KB single-port RAM: one write or read burst of
// 1..256 sequential bytes at a time, addresses wrapping modulo the RAM size.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int LEN_WIDTH  = RAM_LEN_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  ram_burst_master_if.master  bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_WRITE = WRITE;
  localparam logic [1:0] S_READ  = READ;
  localparam logic [1:0] S_DRAIN = DRAIN;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  cnt;
  logic                  iss_valid;
  logic                  iss_last;
  logic                  rd_fin;

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.wdata_ready = (state == S_WRITE);
  assign bus.dbg_state   = state_e'(state);

  assign iss_valid = (state == S_READ);
  assign iss_last  = (cnt == len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cur_addr        <= '0;
      len             <= '0;
      cnt             <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_data_in <= '0;
      bus.done        <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      bus.done   <= rd_fin;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            len <= bus.req_len;
            cnt <= '0;
            if (bus.req_write) begin
              state    <= S_WRITE;
              cur_addr <= bus.req_addr;
            end else begin
              // The first read address goes out on the accepting edge.
              state           <= S_READ;
              bus.mem_address <= bus.req_addr;
              cur_addr        <= bus.req_addr + ADDR_WIDTH'(1);
            end
          end
        end
        S_WRITE: begin
          if (bus.wdata_valid) begin
            bus.mem_we      <= 1'b1;
            bus.mem_address <= cur_addr;
            bus.mem_data_in <= bus.wdata;
            cur_addr        <= cur_addr + ADDR_WIDTH'(1);
            cnt             <= cnt + LEN_WIDTH'(1);
            if (cnt == len) begin
              state    <= S_IDLE;
              bus.done <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (cnt == len) begin
            state <= S_DRAIN;
          end else begin
            cnt             <= cnt + LEN_WIDTH'(1);
            bus.mem_address <= cur_addr;
            cur_addr        <= cur_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_rd_pipe (
    .clk          (clk),
    .rst          (rst),
    .iss_valid    (iss_valid),
    .iss_last     (iss_last),
    .mem_data_out (bus.mem_data_out),
    .rdata_valid  (bus.rdata_valid),
    .rdata        (bus.rdata),
    .rdata_last   (bus.rdata_last),
    .last_pending (rd_fin)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural 64KB RAM attached.
module tb_ram_burst_master;
  import ram_pkg::*;

  logic clk;
  logic rst;

  ram_burst_master_if bus ();

  ram_burst_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  bit [7:0]   ram [0:RAM_DEPTH-1];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] wdat_q [$];
  bit         wpat_q [$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: data_out is registered and only refreshed on non-write cycles
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_address] <= bus.mem_data_in;
    else            bus.mem_data_out     <= ram[bus.mem_address];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: write burst following wdat_q / wpat_q
  task automatic do_write(input logic [15:0] addr, input burst_len_t len);
    int          beat = 0;
    logic [15:0] a;
    bit          last;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len;
    step();
    bus.req_valid = 1'b0;
    check("wr_state", 16'(bus.dbg_state), 16'(WRITE));
    check("wr_wdata_ready", 16'(bus.wdata_ready), 16'd1);
    foreach (wpat_q[i]) begin
      bus.wdata_valid = wpat_q[i];
      bus.wdata       = wpat_q[i] ? wdat_q[beat] : 8'h00;
      step();
      check("wr_we", 16'(bus.mem_we), 16'(wpat_q[i]));
      if (wpat_q[i]) begin
        a = addr + 16'(beat);
        check("wr_addr", bus.mem_address, a);
        check("wr_data", 16'(bus.mem_data_in), 16'(wdat_q[beat]));
        beat++;
      end
      last = wpat_q[i] && (beat == int'(len) + 1);
      check("wr_done", 16'(bus.done), 16'(last));
      check("wr_req_ready", 16'(bus.req_ready), 16'(last));
    end
    bus.wdata_valid = 1'b0;
    bus.wdata       = 8'h00;
    step();
    check("wr_idle_we", 16'(bus.mem_we), 16'd0);
    check("wr_idle_done", 16'(bus.done), 16'd0);
  endtask

  // driver + scoreboard: read burst, beats compared against exp_q
  task automatic do_read(input logic [15:0] addr, input burst_len_t len);
    int          last_c = int'(len) + 3;
    int          beats  = 0;
    logic [15:0] a;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    bus.req_len   = len;
    step();
    bus.req_valid = 1'b0;
    check("rd_state", 16'(bus.dbg_state), 16'(READ));
    for (int c = 1; c <= last_c; c++) begin
      if (c <= int'(len) + 1) begin
        a = addr + 16'(c - 1);
        check("rd_addr", bus.mem_address, a);
        check("rd_we", 16'(bus.mem_we), 16'd0);
      end
      check("rd_valid", 16'(bus.rdata_valid), 16'(c >= 3));
      if (bus.rdata_valid === 1'b1 && exp_q.size() > 0) begin
        beats++;
        check("rd_data", 16'(bus.rdata), 16'(exp_q.pop_front()));
      end
      check("rd_last", 16'(bus.rdata_last), 16'(c == last_c));
      check("rd_done", 16'(bus.done), 16'(c == last_c));
      check("rd_req_ready", 16'(bus.req_ready), 16'(c == last_c));
      if (c < last_c) step();
    end
    check("rd_beats", 16'(beats), 16'(int'(len) + 1));
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_addr    = '0;
    bus.req_len     = '0;
    bus.wdata_valid = 1'b0;
    bus.wdata       = '0;
    step();
    step();
    check("rst_req_ready", 16'(bus.req_ready), 16'd1);
    check("rst_wdata_ready", 16'(bus.wdata_ready), 16'd0);
    check("rst_we", 16'(bus.mem_we), 16'd0);
    check("rst_addr", bus.mem_address, 16'h0000);
    check("rst_din", 16'(bus.mem_data_in), 16'h0000);
    check("rst_rvalid", 16'(bus.rdata_valid), 16'd0);
    check("rst_rdata", 16'(bus.rdata), 16'h0000);
    check("rst_rlast", 16'(bus.rdata_last), 16'd0);
    check("rst_done", 16'(bus.done), 16'd0);
    check("rst_state", 16'(bus.dbg_state), 16'(IDLE));
    rst = 1'b0;
    step();

    // basic write then read back
    wdat_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    wpat_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    do_write(16'h0010, 8'd3);
    check("ram_0010", 16'(ram[16'h0010]), 16'h00A0);
    check("ram_0011", 16'(ram[16'h0011]), 16'h00A1);
    check("ram_0012", 16'(ram[16'h0012]), 16'h00A2);
    check("ram_0013", 16'(ram[16'h0013]), 16'h00A3);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_read(16'h0010, 8'd3);
    step();

    // address wrap across 0xFFFF
    wdat_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    wpat_q = '{1'b1, 1'b1, 1'b1, 1'b1};
    do_write(16'hFFFE, 8'd3);
    check("ram_fffe", 16'(ram[16'hFFFE]), 16'h0011);
    check("ram_ffff", 16'(ram[16'hFFFF]), 16'h0022);
    check("ram_0000", 16'(ram[16'h0000]), 16'h0033);
    check("ram_0001", 16'(ram[16'h0001]), 16'h0044);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_read(16'hFFFE, 8'd3);
    step();

    // gapped write stream
    wdat_q = '{8'h51, 8'h52, 8'h53, 8'h54};
    wpat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_write(16'h0180, 8'd3);
    check("ram_0180", 16'(ram[16'h0180]), 16'h0051);
    check("ram_0183", 16'(ram[16'h0183]), 16'h0054);

    // 256-beat read over 0x0100..0x01FF, then an immediate back-to-back request
    exp_q = {};
    for (int i = 0; i < 256; i++) exp_q.push_back(8'h00);
    exp_q[8'h80] = 8'h51;
    exp_q[8'h81] = 8'h52;
    exp_q[8'h82] = 8'h53;
    exp_q[8'h83] = 8'h54;
    do_read(16'h0100, 8'hFF);
    exp_q = '{8'hA2, 8'hA3};
    do_read(16'h0012, 8'd1);
    step();

    // reset while read beat 2 of an 8-beat burst is on the bus
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 16'h0010;
    bus.req_len   = 8'd7;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    check("abort_b0_valid", 16'(bus.rdata_valid), 16'd1);
    check("abort_b0_data", 16'(bus.rdata), 16'h00A0);
    step();
    step();
    check("abort_b2_data", 16'(bus.rdata), 16'h00A2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_rvalid", 16'(bus.rdata_valid), 16'd0);
    check("abort_rlast", 16'(bus.rdata_last), 16'd0);
    check("abort_done", 16'(bus.done), 16'd0);
    check("abort_req_ready", 16'(bus.req_ready), 16'd1);
    check("abort_state", 16'(bus.dbg_state), 16'(IDLE));
    check("abort_we", 16'(bus.mem_we), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_abort_rvalid", 16'(bus.rdata_valid), 16'd0);
      check("post_abort_done", 16'(bus.done), 16'd0);
    end
    exp_q = '{8'hA0};
    do_read(16'h0010, 8'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator for the single-port 64KB synchronous RAM. Drives its address, data_in and we pins, and takes its registered data_out.
- Client side: one request handshake for a burst of 1..256 sequential byte beats, either write or read. Also a write-data stream and a read-data stream.
- Sits between a client (DMA, CPU bridge, test sequencer) and the RAM. Only this block drives the RAM pins.

Parameters:
- ADDR_WIDTH, 16, RAM address width (byte-addressed, 65536 locations)
- DATA_WIDTH, 8, RAM data width
- LEN_WIDTH, 8, burst length field width; a burst has req_len+1 beats

Ports:
- clk  in  1  single clock; all logic is posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  burst request valid
- req_ready  out  1  high only in IDLE
- req_write  in  1  1=write burst, 0=read burst
- req_addr  in  ADDR_WIDTH  start address
- req_len  in  LEN_WIDTH  beats minus one
- wdata_valid  in  1  write beat valid
- wdata_ready  out  1  high only in WRITE state
- wdata  in  DATA_WIDTH  write beat data
- rdata_valid  out  1  read beat valid; no backpressure, client must accept
- rdata  out  DATA_WIDTH  read beat data
- rdata_last  out  1  final read beat of the burst
- done  out  1  one-cycle pulse at burst completion
- mem_address  out  ADDR_WIDTH  to RAM address
- mem_data_in  out  DATA_WIDTH  to RAM data_in
- mem_we  out  1  to RAM we
- mem_data_out  in  DATA_WIDTH  from RAM data_out (registered in RAM)

Behaviour:
- Reset values: state IDLE, req_ready=1, wdata_ready=0, mem_we=0, mem_address=0, mem_data_in=0, rdata_valid=0, rdata=0, rdata_last=0, done=0, beat counter=0.
- All mem_* outputs and all client outputs are registered, except req_ready and wdata_ready, which decode the state.
- The RAM updates data_out only when we=0. This block never relies on data_out during or after a write cycle.
- States:
  - IDLE: on req_valid, latch addr and len, then go to WRITE or READ.
  - WRITE: on each wdata handshake, set mem_we=1, mem_address=cur_addr and mem_data_in=wdata on the next edge. Then increment cur_addr and the beat counter. Without a handshake, mem_we=0 next cycle.
  - After the handshake of beat req_len: state becomes IDLE and done=1. These coincide with the cycle in which the last mem_we=1 is presented.
  - READ: issue one address per cycle with mem_we=0, mem_address=cur_addr. No stalls. Runs req_len+1 cycles, then goes to DRAIN.
  - DRAIN: one cycle, to collect the final beat. Then IDLE.
- Read latency:
  - Request accepted at edge E0. First mem_address is valid in cycle 1 (after E0).
  - RAM data_out is valid in cycle 2. That data is registered into rdata, so rdata_valid=1 in cycle 3.
  - Beats then follow back to back: beat k is in cycle 3+k.
  - rdata_last and done both assert with beat req_len. req_ready is high again in that same cycle.
- Address arithmetic: cur_addr increments modulo 2^ADDR_WIDTH, so 0xFFFF wraps to 0x0000 mid-burst with no error. The beat counter is LEN_WIDTH wide; req_len=0xFF gives 256 beats.
- Request acceptance:
  - Requests are accepted only in IDLE and never overlap.
  - A req_valid held while busy is ignored until IDLE.
  - The request fields are sampled only on the handshake.
- Write stream gaps: wdata_valid may drop at any time, which inserts idle RAM cycles (mem_we=0). Beat order is preserved.
- Reset mid-burst:
  - At the next edge: mem_we=0, and the state and counters are cleared.
  - In-flight read beats are discarded: rdata_valid=0, with no rdata_last or done for the aborted burst.
  - RAM contents already written stay written.
- done never asserts in IDLE except on the completion cycle. done and rdata_valid are never X after reset.

Decomposition:
- Shared package ram_pkg holds:
  - RAM_ADDR_WIDTH=16, RAM_DATA_WIDTH=8, RAM_DEPTH=65536
  - the state enum {IDLE, WRITE, READ, DRAIN}
  - the burst length type
- One sub-module is natural: ram_rd_pipe, a 2-stage valid/last shift register that aligns the issued read beats with the RAM's registered output.

Test Plan:
- Write burst addr=0x0010, len=3, data 0xA0..0xA3, wdata_valid held high -> 4 consecutive cycles mem_we=1, addresses 0x10..0x13. done pulses with the last beat. RAM holds A0..A3.
- Read burst addr=0x0010, len=3 after the above -> rdata_valid for 4 consecutive cycles, starting 3 cycles after the handshake. Data A0,A1,A2,A3. rdata_last and done on A3.
- Wrap: write addr=0xFFFE, len=3, data 11,22,33,44, then read back -> locations FFFE=11, FFFF=22, 0000=33, 0001=44. Reads return the same order.
- Gapped writes: wdata_valid pattern 1,0,0,1,1,0,1 for len=3 -> mem_we pattern mirrors the handshakes one cycle later. Data is correct. req_ready stays low until done.
- Max length: read len=0xFF from 0x0100 -> exactly 256 rdata_valid beats. rdata_last only on the 256th. Back-to-back request accepted the cycle after done.
- Reset at read beat 2 of len=7 -> rdata_valid=0 from the next cycle. No done or rdata_last. req_ready=1. A subsequent read of len=0 at 0x0010 returns 0xA0.
